// File: rtl/step_pulse_gen_if.sv
// GPIO0 PIO command/status word pair between the HPS and step_pulse_gen.
interface step_pulse_gen_if;
  logic [31:0] cmd_word;
  logic [31:0] status_word;

  modport master (output cmd_word, input status_word);
  modport slave  (input cmd_word, output status_word);
endinterface

// File: rtl/step_pulse_gen.sv
// Stepper step/dir pulse generator driven by a toggle-handshaked command word from the HPS PIO.
// Optional build macro STEP_ENDSTOP_EN: a synchronised endstop stops the move after the current high pulse.
module step_pulse_gen #(
  parameter int PULSE_W   = 100,
  parameter int DIR_SETUP = 50
) (
  input  logic            clk_clk,
  input  logic            reset_reset,
  step_pulse_gen_if.slave gpio,
  output logic            step_out,
  output logic            dir_out,
  output logic            busy,
  input  logic            endstop
);
  localparam int CNT_W = 17;
  localparam logic [CNT_W-1:0] PULSE_LEN  = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] MIN_PER    = CNT_W'(2 * PULSE_W);
  localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIR_SETUP, S_STEP_HIGH, S_STEP_LOW} state_t;

  function automatic logic [CNT_W-1:0] clamp_period(input logic [15:0] per);
    logic [CNT_W-1:0] p17;
    p17 = {1'b0, per};
    return (p17 < MIN_PER) ? MIN_PER : p17;
  endfunction

  function automatic logic [CNT_W-1:0] low_last(input logic [CNT_W-1:0] per_eff);
    return per_eff - PULSE_LEN - CNT_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   per_q, per_d;
  logic [12:0]        rem_q, rem_d;
  logic               step_q, step_d;
  logic               dir_q, dir_d;
  logic               busy_q, busy_d;
  logic               stop_q, stop_d;
  logic               tog_q, tog_d;
  logic               ack_q, ack_d;
  logic               pend_vld_q, pend_vld_d;
  logic               pend_dir_q, pend_dir_d;
  logic [12:0]        pend_cnt_q, pend_cnt_d;
  logic [15:0]        pend_per_q, pend_per_d;
  logic               ovf_q, ovf_d;
  logic               es_hit_q, es_hit_d;

  logic               cmd_tog, cmd_dir, cmd_abort, new_cmd;
  logic [12:0]        cmd_cnt;
  logic [15:0]        cmd_per;

  logic               do_load, ld_dir, stop_req;
  logic [12:0]        ld_cnt;
  logic [15:0]        ld_per;

  assign {cmd_tog, cmd_dir, cmd_abort, cmd_cnt, cmd_per} = gpio.cmd_word;
  assign new_cmd = cmd_tog ^ tog_q;

`ifdef STEP_ENDSTOP_EN
  logic es_p0, es_p1, es_p2, es_evt;

  // Edge-triggered so a move started while the endstop is already high runs normally.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      es_p0 <= 1'b0;
      es_p1 <= 1'b0;
      es_p2 <= 1'b0;
    end else begin
      es_p0 <= endstop;
      es_p1 <= es_p0;
      es_p2 <= es_p1;
    end
  end

  assign es_evt = es_p1 & ~es_p2 & busy_q;
`else
  logic unused_endstop;
  assign unused_endstop = endstop;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_d     = step_q;
    dir_d      = dir_q;
    busy_d     = busy_q;
    rem_d      = rem_q;
    per_d      = per_q;
    stop_d     = stop_q;
    tog_d      = cmd_tog;
    ack_d      = ack_q;
    pend_vld_d = pend_vld_q;
    pend_dir_d = pend_dir_q;
    pend_cnt_d = pend_cnt_q;
    pend_per_d = pend_per_q;
    ovf_d      = ovf_q;
    es_hit_d   = es_hit_q;
    do_load    = 1'b0;
    ld_dir     = pend_dir_q;
    ld_cnt     = pend_cnt_q;
    ld_per     = pend_per_q;
    stop_req   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pend_vld_q) begin
          do_load    = 1'b1;
          pend_vld_d = 1'b0;
        end
      end
      S_DIR_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STEP_HIGH;
          cnt_d   = HIGH_LAST;
          step_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STEP_HIGH: begin
        if (cnt_q == '0) begin
          if (stop_q) begin
            stop_req = 1'b1;
          end else begin
            state_d = S_STEP_LOW;
            step_d  = 1'b0;
            cnt_d   = low_last(per_q);
            rem_d   = rem_q - 13'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STEP_LOW: begin
        if (cnt_q == '0) begin
          if (rem_q != 13'd0) begin
            state_d = S_STEP_HIGH;
            cnt_d   = HIGH_LAST;
            step_d  = 1'b1;
          end else if (pend_vld_q) begin
            do_load    = 1'b1;
            pend_vld_d = 1'b0;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase

    // Every toggle change is acknowledged, including dropped and zero-count commands.
    if (new_cmd) begin
      ack_d = ~ack_q;
      if (cmd_abort) begin
        pend_vld_d = 1'b0;
        ovf_d      = 1'b0;
        es_hit_d   = 1'b0;
        stop_req   = 1'b1;
      end else if (cmd_cnt != 13'd0) begin
        if (!busy_q && !pend_vld_q) begin
          do_load = 1'b1;
          ld_dir  = cmd_dir;
          ld_cnt  = cmd_cnt;
          ld_per  = cmd_per;
        end else if (pend_vld_q) begin
          ovf_d = 1'b1;
        end else begin
          pend_vld_d = 1'b1;
          pend_dir_d = cmd_dir;
          pend_cnt_d = cmd_cnt;
          pend_per_d = cmd_per;
        end
      end
    end

`ifdef STEP_ENDSTOP_EN
    if (es_evt) begin
      es_hit_d   = 1'b1;
      pend_vld_d = 1'b0;
      stop_req   = 1'b1;
    end
`endif

    if (do_load) begin
      busy_d = 1'b1;
      rem_d  = ld_cnt;
      per_d  = clamp_period(ld_per);
      stop_d = 1'b0;
      if (ld_dir != dir_q) begin
        dir_d   = ld_dir;
        state_d = S_DIR_SETUP;
        cnt_d   = SETUP_LAST;
        step_d  = 1'b0;
      end else begin
        state_d = S_STEP_HIGH;
        cnt_d   = HIGH_LAST;
        step_d  = 1'b1;
      end
    end

    // A high pulse already on the pins always runs to its full width before stopping.
    if (stop_req) begin
      if (state_q == S_STEP_HIGH && cnt_q != '0) begin
        stop_d = 1'b1;
      end else begin
        state_d = S_IDLE;
        step_d  = 1'b0;
        busy_d  = 1'b0;
        rem_d   = 13'd0;
        cnt_d   = '0;
        stop_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      busy_q     <= 1'b0;
      rem_q      <= 13'd0;
      stop_q     <= 1'b0;
      tog_q      <= 1'b0;
      ack_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      es_hit_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      busy_q     <= busy_d;
      rem_q      <= rem_d;
      stop_q     <= stop_d;
      tog_q      <= tog_d;
      ack_q      <= ack_d;
      pend_vld_q <= pend_vld_d;
      ovf_q      <= ovf_d;
      es_hit_q   <= es_hit_d;
    end
  end

  always_ff @(posedge clk_clk) begin
    per_q      <= per_d;
    pend_dir_q <= pend_dir_d;
    pend_cnt_q <= pend_cnt_d;
    pend_per_q <= pend_per_d;
  end

  assign step_out         = step_q;
  assign dir_out          = dir_q;
  assign busy             = busy_q;
  assign gpio.status_word = {ack_q, busy_q, pend_vld_q, ovf_q, es_hit_q, 14'd0, rem_q};
endmodule

// File: tb/tb_step_pulse_gen.sv
// Testbench for step_pulse_gen: directed scenarios plus randomized moves against a pulse-schedule model.
`timescale 1ns/1ps
module tb_step_pulse_gen;
  localparam int PW = 100;
  localparam int DS = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic endstop = 1'b0;
  logic step_out, dir_out, busy;
  step_pulse_gen_if gpio();

  step_pulse_gen #(.PULSE_W(PW), .DIR_SETUP(DS)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .gpio        (gpio),
    .step_out    (step_out),
    .dir_out     (dir_out),
    .busy        (busy),
    .endstop     (endstop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {int rise; logic dir;} pulse_t;
  pulse_t exp_q[$];

  logic m_dir = 1'b0;
  int   m_end = 0;
  logic exp_ack = 1'b0;
  logic tog = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every rising step edge is matched against the next scheduled pulse.
  initial begin
    logic prev_step;
    int   rise_cyc;
    bit   in_pulse;
    pulse_t p;
    prev_step = 1'b0;
    rise_cyc  = 0;
    in_pulse  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_step = 1'b0;
        in_pulse  = 0;
      end else begin
        if (step_out && !prev_step) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pulse: rise at cycle %0d, required none", cyc);
          end else begin
            p = exp_q.pop_front();
            check("rise_cycle", 32'(cyc), 32'(p.rise));
            check("rise_dir", 32'(dir_out), 32'(p.dir));
          end
          rise_cyc = cyc;
          in_pulse = 1;
        end else if (!step_out && prev_step && in_pulse) begin
          check("high_width", 32'(cyc - rise_cyc), 32'(PW));
          in_pulse = 0;
        end
        prev_step = step_out;
      end
    end
  end

  task automatic push_move(input logic d, input int c, input int p, input int base);
    int pe, s;
    pe = (p < 2 * PW) ? 2 * PW : p;
    s  = base + ((d != m_dir) ? DS : 0);
    for (int i = 0; i < c; i++) exp_q.push_back('{rise: s + i * pe, dir: d});
    m_dir = d;
    m_end = s + c * pe;
  endtask

  task automatic trim_after(input int k);
    while (exp_q.size() > 0 && exp_q[$].rise > k) void'(exp_q.pop_back());
  endtask

  // mode 0: starts from idle; 1: queued behind the running move; 2: not expected to run
  task automatic issue(input logic d, input logic ab, input int c, input int p, input int mode,
                       output int k);
    @(negedge clk);
    tog = ~tog;
    gpio.cmd_word = {tog, d, ab, 13'(c), 16'(p)};
    k = cyc;
    exp_ack = ~exp_ack;
    if (ab) trim_after(k);
    else if (c != 0 && mode == 0) push_move(d, c, p, k + 1);
    else if (c != 0 && mode == 1) push_move(d, c, p, m_end);
    @(negedge clk);
    check("ack", 32'(gpio.status_word[31]), 32'(exp_ack));
  endtask

  task automatic wait_end(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 6000 && !done; i++) begin
      @(negedge clk);
      if (!gpio.status_word[30]) done = 1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s: busy still high after 6000 cycles, required low at cycle %0d", name, m_end);
    end else begin
      check(name, 32'(cyc), 32'(m_end));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, kk, c, p, gap;
    logic d;
    gpio.cmd_word = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_status", gpio.status_word, 32'd0);
    check("reset_outs", {29'd0, step_out, dir_out, busy}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic 3-pulse move, same direction
    issue(1'b0, 1'b0, 3, 400, 0, k);
    check("first_status", gpio.status_word, 32'hC000_0003);
    check("first_step", 32'(step_out), 32'd1);
    wait_end("basic_end");

    // Direction change inserts setup time
    issue(1'b1, 1'b0, 2, 400, 0, k);
    check("dir_change_dir", 32'(dir_out), 32'd1);
    check("dir_change_step", 32'(step_out), 32'd0);
    check("dir_change_rem", 32'(gpio.status_word[12:0]), 32'd2);
    wait_end("dir_change_end");

    // Short period clamps to 2*PULSE_W
    issue(1'b1, 1'b0, 2, 50, 0, k);
    wait_end("clamp_end");

    // Three back-to-back commands: one queued, one dropped
    issue(1'b0, 1'b0, 2, 300, 0, k);
    issue(1'b1, 1'b0, 1, 250, 1, k);
    check("pend_set", 32'(gpio.status_word[29:28]), 32'b10);
    issue(1'b0, 1'b0, 3, 300, 2, k);
    check("ovf_set", 32'(gpio.status_word[29:28]), 32'b11);
    wait_end("chain_end");

    // Abort 10 cycles into a high pulse
    issue(1'b1, 1'b0, 3, 400, 0, k);
    issue(1'b1, 1'b0, 1, 300, 1, kk);
    check("abort_pre_pend", 32'(gpio.status_word[29]), 32'd1);
    repeat (7) @(negedge clk);
    issue(1'b0, 1'b1, 0, 0, 2, kk);
    check("abort_hi_flags", 32'(gpio.status_word[30:28]), 32'b100);
    check("abort_hi_step", 32'(step_out), 32'd1);
    m_end = k + 1 + PW;
    wait_end("abort_hi_end");

    // Abort during a low phase stops at once
    issue(1'b1, 1'b0, 2, 400, 0, k);
    repeat (148) @(negedge clk);
    issue(1'b0, 1'b1, 0, 0, 2, kk);
    check("abort_lo_status", gpio.status_word, {exp_ack, 31'd0});
    check("abort_lo_step", 32'(step_out), 32'd0);

    // Zero-count command: ack only, no direction change
    issue(1'b0, 1'b0, 0, 123, 0, k);
    check("zero_cnt_status", gpio.status_word, {exp_ack, 31'd0});
    check("zero_cnt_dir", 32'(dir_out), 32'd1);

    // Endstop raised mid-pulse with a queued command
    issue(1'b1, 1'b0, 3, 300, 0, k);
    issue(1'b1, 1'b0, 2, 300, 1, kk);
    repeat (17) @(negedge clk);
    @(negedge clk);
    endstop = 1'b1;
    repeat (5) @(negedge clk);
`ifdef STEP_ENDSTOP_EN
    check("endstop_flags", 32'(gpio.status_word[30:27]), 32'b1001);
    trim_after(cyc);
    m_end = k + 1 + PW;
`else
    check("endstop_flags", 32'(gpio.status_word[30:27]), 32'b1100);
`endif
    endstop = 1'b0;
    wait_end("endstop_end");

    // Reset mid-move
    issue(1'b0, 1'b0, 3, 300, 0, k);
    repeat (69) @(negedge clk);
    rst = 1'b1;
    gpio.cmd_word = 32'd0;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_status", gpio.status_word, 32'd0);
    check("rst_mid_outs", {29'd0, step_out, dir_out, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tog = 1'b0;
    exp_ack = 1'b0;
    m_dir = 1'b0;
    @(negedge clk);

    // Randomized moves, optionally with one queued follow-up
    for (int it = 0; it < 10; it++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      d = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 3));
      p = int'($urandom_range(20, 450));
      issue(d, 1'b0, c, p, 0, k);
      if (c == 0) begin
        check("rand_zero_busy", 32'(gpio.status_word[30]), 32'd0);
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          gap = int'($urandom_range(0, 18));
          repeat (gap) @(negedge clk);
          issue(1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(0, 3)),
                int'($urandom_range(20, 450)), 1, kk);
        end
        wait_end("rand_end");
      end
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
